// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-port data memory.
// Each grant runs IDLE -> ACCESS -> RESP, giving the winner a one-cycle ack.
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [31:0]       addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [31:0]       addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic              mem_we,
  output logic              mem_re,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                win_q, win_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                oor_q, oor_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                ack0_q, ack0_d, ack1_q, ack1_d;
  logic                err0_q, err0_d, err1_q, err1_d;
  logic                pick1;
  logic [31:0]         addr_sel;
  logic [DATA_W-1:0]   rd_val;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    win_d        = win_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    oor_d        = oor_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    pick1        = 1'b0;
    addr_sel     = '0;
    rd_val       = oor_q ? '0 : mem_rdata;

    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // Port 1 wins alone, or on a conflict when port 0 was granted last.
          pick1    = req1 && (!req0 || !last_grant_q);
          addr_sel = pick1 ? addr1 : addr0;
          win_d    = pick1;
          we_d     = pick1 ? we1 : we0;
          addr_d   = addr_sel;
          wdata_d  = pick1 ? wdata1 : wdata0;
          oor_d    = addr_sel >= 32'(DEPTH);
          state_d  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        last_grant_d = win_q;
        // Writes leave the port's last read result untouched.
        if (!we_q) begin
          if (win_q) rdata1_d = rd_val;
          else       rdata0_d = rd_val;
        end
        ack0_d  = !win_q;
        ack1_d  = win_q;
        err0_d  = !win_q && oor_q;
        err1_d  = win_q && oor_q;
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      win_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      oor_q        <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      oor_q        <= oor_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
    end
  end

  // Memory pins decode only from state and latched fields; out-of-range accesses stay dark.
  logic acc_ok;
  assign acc_ok    = (state_q == S_ACCESS) && !oor_q;
  assign mem_we    = acc_ok && we_q;
  assign mem_re    = acc_ok && !we_q;
  assign mem_addr  = acc_ok ? addr_q : '0;
  assign mem_wdata = acc_ok ? wdata_q : '0;
  assign busy      = (state_q != S_IDLE);

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign err0   = err0_q;
  assign err1   = err1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed transactions push expected acks,
// a monitor pops and compares on every ack; includes a 64-word memory model.
module tb_dmem_arbiter;

  logic        clk, reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1, busy, mem_we, mem_re;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.DATA_W(32), .DEPTH(64)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge, cleared by reset.
  logic [31:0] mem [64];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_addr[5:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[5:0]];

  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    bit          chk;
    int          cyc;
  } sb_item_t;

  sb_item_t sb[$];
  int n_tests = 0, n_fail = 0;
  int we_cnt = 0, re_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input int p, input logic [31:0] rd, input logic e, input bit chk, input int c);
    sb_item_t it;
    it.port = p; it.rdata = rd; it.err = e; it.chk = chk; it.cyc = c;
    sb.push_back(it);
  endtask

  // Monitor: pops one expectation per ack and compares port, timing, err and data.
  initial begin
    sb_item_t it;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mem_we) we_cnt++;
        if (mem_re) re_cnt++;
        if (ack0 && ack1) check("ack_both", 32'd1, 32'd0);
        if ((err0 && !ack0) || (err1 && !ack1)) check("err_no_ack", 32'd1, 32'd0);
        if (ack0 || ack1) begin
          if (sb.size() == 0) begin
            check("unexpected_ack", 32'd1, 32'd0);
          end else begin
            it = sb.pop_front();
            check("ack_port", {31'd0, ack1}, 32'(it.port));
            check("ack_cycle", 32'(cyc), 32'(it.cyc));
            check("err", {31'd0, ack1 ? err1 : err0}, {31'd0, it.err});
            if (it.chk) check("rdata", ack1 ? rdata1 : rdata0, it.rdata);
          end
        end
      end
    end
  end

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  // Requester: runs n ops (index 0 first), keeping req high across consecutive ops.
  task automatic run_port(input int p, input int n, input logic [2:0] we_v,
                          input logic [2:0][31:0] addr_v, input logic [2:0][31:0] wd_v);
    bit got;
    for (int i = 0; i < n; i++) begin
      set_port(p, 1'b1, we_v[i], addr_v[i], wd_v[i]);
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        got = (p == 0) ? ack0 : ack1;
      end
      if (!got) begin
        check("ack_timeout", 32'd0, 32'd1);
        break;
      end
    end
    set_port(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      #1;
      ok = (sb.size() == 0) && !busy;
    end
    if (!ok) begin
      check("drain_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  task automatic single(input string tag, input int p, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err,
                        input bit chk, input int exp_we, input int exp_re);
    int c, we0_s, re0_s;
    @(negedge clk);
    we0_s = we_cnt; re0_s = re_cnt; c = cyc;
    push(p, exp_rd, exp_err, chk, c + 2);
    run_port(p, 1, {2'b00, w}, {64'd0, a}, {64'd0, d});
    drain();
    check({tag, "_mem_we_cycles"}, 32'(we_cnt - we0_s), 32'(exp_we));
    check({tag, "_mem_re_cycles"}, 32'(re_cnt - re0_s), 32'(exp_re));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack0"}, {31'd0, ack0}, 32'd0);
    check({tag, "_ack1"}, {31'd0, ack1}, 32'd0);
    check({tag, "_err0"}, {31'd0, err0}, 32'd0);
    check({tag, "_err1"}, {31'd0, err1}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_re"}, {31'd0, mem_re}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_rdata0"}, rdata0, 32'd0);
    check({tag, "_rdata1"}, rdata1, 32'd0);
  endtask

  initial begin
    int c, lows;
    clk = 0; reset = 0;
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    #1 reset = 1;
    #1 check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    reset = 0;

    // Conflict from reset: grants 0,1,0,1 at 3-cycle spacing.
    @(negedge clk);
    c = cyc;
    push(0, 32'h0, 1'b0, 0, c + 2);
    push(1, 32'h0, 1'b0, 0, c + 5);
    push(0, 32'hA0A00001, 1'b0, 1, c + 8);
    push(1, 32'hA0A00001, 1'b0, 1, c + 11);
    fork
      run_port(0, 2, 3'b001, {32'd0, 32'd10, 32'd10}, {32'd0, 32'd0, 32'hA0A00001});
      run_port(1, 2, 3'b001, {32'd0, 32'd10, 32'd11}, {32'd0, 32'd0, 32'hB1B10002});
    join
    drain();

    // Port 0 write/read round trip.
    single("p0_wr5", 0, 1'b1, 32'd5, 32'hDEADBEEF, 32'h0, 1'b0, 0, 1, 0);
    single("p0_rd5", 0, 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, 1, 0, 1);

    // Port 1 out-of-range accesses, then the top legal word.
    single("p1_wr64", 1, 1'b1, 32'd64, 32'hFFFFFFFF, 32'h0, 1'b1, 0, 0, 0);
    single("p1_rd100", 1, 1'b0, 32'd100, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    single("p1_wr63", 1, 1'b1, 32'd63, 32'h63636363, 32'h0, 1'b0, 0, 1, 0);
    single("p1_rd63", 1, 1'b0, 32'd63, 32'h0, 32'h63636363, 1'b0, 1, 0, 1);

    // Cross-port visibility.
    single("p1_wr7", 1, 1'b1, 32'd7, 32'h00001234, 32'h0, 1'b0, 0, 1, 0);
    single("p0_rd7", 0, 1'b0, 32'd7, 32'h0, 32'h00001234, 1'b0, 1, 0, 1);

    // Port 0 holds req for three back-to-back reads.
    @(negedge clk);
    c = cyc; lows = 0;
    push(0, 32'hDEADBEEF, 1'b0, 1, c + 2);
    push(0, 32'h63636363, 1'b0, 1, c + 5);
    push(0, 32'h00001234, 1'b0, 1, c + 8);
    fork
      run_port(0, 3, 3'b000, {32'd7, 32'd63, 32'd5}, {32'd0, 32'd0, 32'd0});
      begin
        repeat (8) begin
          @(negedge clk);
          if (!busy) lows++;
        end
      end
    join
    check("b2b_busy_low_cycles", 32'(lows), 32'd2);
    drain();

    // Reset in the ACCESS cycle of a port 0 write: dropped, no ack.
    @(negedge clk);
    set_port(0, 1'b1, 1'b1, 32'd3, 32'h33333333);
    @(negedge clk);
    check("mid_access_mem_we", {31'd0, mem_we}, 32'd1);
    reset = 1;
    #1 check_outputs_zero("mid_reset");
    set_port(0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);
    c = cyc;
    push(0, 32'h0, 1'b0, 1, c + 2);
    push(1, 32'h0, 1'b0, 1, c + 5);
    fork
      run_port(0, 1, 3'b000, {64'd0, 32'd3}, {96'd0});
      run_port(1, 1, 3'b000, {64'd0, 32'd4}, {96'd0});
    join
    drain();

    check("sb_leftover", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the single-port 64-word data memory. Port 0 is the core load/store path; port 1 is the debug/DMA loader. Each accepted request becomes one registered memory access, and the requester gets a one-cycle acknowledge with registered read data. The block sits between both requesters and the memory's `MemWrite`/`MemRead`/address/data pins, and owns them exclusively.

## Interface
- `DATA_W`, 32, data width
- `DEPTH`, 64, memory words; legal word addresses are 0..DEPTH-1
- `clk` in 1 rising-edge clock
- `reset` in 1 asynchronous, active-high
- `req0`/`req1` in 1 request, held high until ack
- `we0`/`we1` in 1 1=write, 0=read; stable while req high
- `addr0`/`addr1` in 32 word address; stable while req high
- `wdata0`/`wdata1` in DATA_W write data; stable while req high
- `ack0`/`ack1` out 1 one-cycle completion pulse
- `rdata0`/`rdata1` out DATA_W read result, valid in ack cycle, held until next ack to that port
- `err0`/`err1` out 1 address out of range; valid in ack cycle only
- `mem_we` out 1 to memory write enable
- `mem_re` out 1 to memory read enable
- `mem_addr` out 32 to memory address
- `mem_wdata` out DATA_W to memory write data
- `mem_rdata` in DATA_W from memory; combinational read of `mem_addr`
- `busy` out 1 high in ACCESS and RESP

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:** if any req is high, choose a winner and latch its `we`, `addr` and `wdata`, plus its port id and a range flag (`addr >= DEPTH`). Then go to ACCESS. Otherwise stay in IDLE.
- **Arbitration:** with a single requester, that requester wins. When both request, the port not granted last wins (round robin). `last_grant` resets to 1, so port 0 wins the first conflict.
- **ACCESS:**
  - In range: drive `mem_addr` = latched addr, `mem_we` = latched we, `mem_re` = !latched we, `mem_wdata` = latched wdata.
  - Out of range: `mem_we` = `mem_re` = 0 and `mem_addr` = 0, so no write occurs.
  - For an in-range read, capture `mem_rdata` into the winner's rdata register on the ACCESS→RESP edge. For out-of-range reads, capture 0.
  - Update `last_grant` and go to RESP.
- **RESP:** pulse the winner's `ack` and assert its `err` if the access was out of range. Memory controls are 0. Go to IDLE.
- **Requester rule:** req must be low on the edge ending the ack cycle unless another transaction is wanted. A req high in IDLE is always treated as a new request.
- The losing requester keeps req high and is served in the next IDLE; starvation is impossible.
- Writes take effect on the memory at the ACCESS→RESP edge. A later read from any port returns the new data.
- Out-of-range writes are dropped. rdata for out-of-range reads is 0, with err set.
- **Reset** (asynchronous, any state): FSM goes to IDLE and any in-flight transaction is dropped without ack. `last_grant` = 1. Latched fields, rdata and all outputs go to 0. The memory clears itself on the same reset.

## Timing
- Reset values: `ack0`/`ack1`/`err0`/`err1`/`busy`/`mem_we`/`mem_re` = 0; `mem_addr`/`mem_wdata`/`rdata0`/`rdata1` = 0.
- All outputs are registered, except that memory controls decode directly from state and latched registers, with no requester-input combinational path.
- Latency: req sampled high in IDLE at edge E0 → ACCESS in cycle 1 → ack in cycle 2 (after edge E2). This is 2 cycles, request-edge to ack.
- Throughput: one transaction per 3 cycles. With both ports requesting continuously, grants alternate 0,1,0,1.
- A req rising during ACCESS or RESP is held off and evaluated in the next IDLE.
- `ack` and `err` are never high for both ports in the same cycle.

## Test plan
- Port 0 writes 0xDEADBEEF to addr 5, then reads addr 5 → ack0 2 cycles after each request, `mem_we` high exactly one cycle, rdata0 = 0xDEADBEEF, err0 = 0.
- req0 and req1 both rise at the same edge, held for 4 transactions total → grant order 0,1,0,1. Each ack is one cycle, spaced 3 cycles apart, and never simultaneous.
- Port 1 writes addr 64, then reads addr 100 → no `mem_we`/`mem_re` pulse, ack1 with err1 = 1, rdata1 = 0. Addr 63 write/read round-trips correctly.
- Port 1 writes 0x1234 to addr 7, and port 0 then reads addr 7 → rdata0 = 0x1234.
- Assert reset in the ACCESS cycle of a port 0 write to addr 3 → no ack. All outputs are 0 immediately. After release, a port 0 read of addr 3 returns 0, and the first conflict grants port 0.
- Port 0 keeps req high through ack for 3 back-to-back reads with port 1 idle → 3 acks at a 3-cycle spacing, with `busy` low exactly one cycle between transactions.
